// File: rtl/priority_encoder_83.sv
// priority_encoder_83: 8-input priority encoder with a request-capture front end.
// Each active-low request line is synchronized and edge-detected. Falling edges
// latch into a pending register. A two-state FSM presents the highest pending
// index and holds it until the consumer acknowledges.
// Optional build macro: ENC83_DEBOUNCE_EN adds a per-line debounce filter of
// DEB_CYCLES samples between the synchronizer and the edge detector.

// Per-line front end: synchronizer, optional debounce filter, falling-edge detect.
module priority_encoder_83_lane #(
    parameter int DEB_CYCLES = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic req_n,
    output logic fall
);
    logic sync1, sync2, cur, prev;

    // Out-of-range debounce lengths leave a named marker block in the hierarchy.
    if (DEB_CYCLES < 2 || DEB_CYCLES > 15) begin : g_deb_cycles_out_of_range
    end

    // Two-flop synchronizer. It idles high so that lines held low at reset release read as new edges.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= 1'b1;
            sync2 <= 1'b1;
        end else begin
            sync1 <= req_n;
            sync2 <= sync1;
        end
    end

`ifdef ENC83_DEBOUNCE_EN
    logic       filt;
    logic [3:0] cnt;

    // The filtered level follows the synchronized input only after it has differed for DEB_CYCLES samples in a row.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            filt <= 1'b1;
            cnt  <= 4'd0;
        end else if (sync2 != filt) begin
            if (cnt == 4'(DEB_CYCLES - 1)) begin
                filt <= sync2;
                cnt  <= 4'd0;
            end else begin
                cnt  <= cnt + 4'd1;
            end
        end else begin
            cnt <= 4'd0;
        end
    end

    assign cur = filt;
`else
    assign cur = sync2;
`endif

    // Previous-value register for 1->0 edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) prev <= 1'b1;
        else        prev <= cur;
    end

    assign fall = prev & ~cur;
endmodule

module priority_encoder_83 #(
    parameter int DEB_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [2:0] en,
    input  logic [7:0] req_n,
    input  logic       ack,
    output logic [2:0] code,
    output logic       valid,
    output logic       gs_n,
    output logic [7:0] pending,
    output logic       ovr
);
    localparam int NUM_LANES = 8;

    typedef enum logic {IDLE, PRESENT} state_t;

    state_t               state_q, state_d;
    logic [NUM_LANES-1:0] fall, set, clr, pend_d;
    logic [2:0]           hi_idx, code_d;
    logic                 valid_d, ovr_hit;

    for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
        priority_encoder_83_lane #(.DEB_CYCLES(DEB_CYCLES)) u_lane (
            .clk   (clk),
            .rst_n (rst_n),
            .req_n (req_n[i]),
            .fall  (fall[i])
        );
    end

    // Captures are gated by the enable only. The clear always targets the presented code.
    assign set     = (en == 3'b001) ? fall : '0;
    assign clr     = (state_q == PRESENT && ack) ? (8'b1 << code) : '0;
    assign pend_d  = (pending & ~clr) | set;
    assign ovr_hit = |(set & pending & ~clr);

    // Highest set pending index. Later iterations override, so bit 7 wins.
    always_comb begin
        hi_idx = 3'd0;
        for (int i = 0; i < NUM_LANES; i++)
            if (pending[i]) hi_idx = 3'(i);
    end

    // Next-state and next-output logic. A presentation holds until ack, with no preemption.
    always_comb begin
        state_d = state_q;
        code_d  = code;
        valid_d = valid;
        case (state_q)
            IDLE: begin
                if (pending != '0) begin
                    code_d  = hi_idx;
                    valid_d = 1'b1;
                    state_d = PRESENT;
                end
            end
            PRESENT: begin
                if (ack) begin
                    code_d  = 3'd0;
                    valid_d = 1'b0;
                    state_d = IDLE;
                end
            end
            default: begin
                code_d  = 3'd0;
                valid_d = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    // State, presentation, pending and sticky overrun registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            code    <= 3'd0;
            valid   <= 1'b0;
            pending <= '0;
            ovr     <= 1'b0;
        end else begin
            state_q <= state_d;
            code    <= code_d;
            valid   <= valid_d;
            pending <= pend_d;
            if (ovr_hit) ovr <= 1'b1;
        end
    end

    assign gs_n = ~((|pending) | valid);
endmodule

// File: tb/tb_priority_encoder_83.sv
// Directed bench for priority_encoder_83. Expected codes go into a scoreboard
// queue when a request is driven, and are popped when the DUT presents.
module tb_priority_encoder_83;
    localparam int DEB = 4;
`ifdef ENC83_DEBOUNCE_EN
    localparam int X = DEB;
`else
    localparam int X = 0;
`endif
    localparam int PW = 2 + X;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [2:0] en;
    logic [7:0] req_n;
    logic       ack;
    logic [2:0] code;
    logic       valid, gs_n, ovr;
    logic [7:0] pending;

    int checks = 0;
    int failures = 0;
    logic [2:0] sb_q[$];

    priority_encoder_83 #(.DEB_CYCLES(DEB)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .req_n(req_n), .ack(ack),
        .code(code), .valid(valid), .gs_n(gs_n), .pending(pending), .ovr(ovr)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Wait a bounded number of cycles for a presentation, then compare it with the scoreboard head.
    task automatic wait_present(input string tag);
        logic [2:0] exp;
        for (int i = 0; i < 40 && valid !== 1'b1; i++) tick(1);
        chk({tag, "_valid"}, valid, 1);
        if (sb_q.size() == 0) begin
            checks++;
            failures++;
            $error("FAIL %s_sb_empty observed=%0h expected=none", tag, code);
        end else begin
            exp = sb_q.pop_front();
            chk({tag, "_code"}, code, exp);
        end
    endtask

    task automatic ack_one(input string tag);
        ack = 1'b1;
        tick(1);
        ack = 1'b0;
        chk({tag, "_ack_valid"}, valid, 0);
        chk({tag, "_ack_code"}, code, 0);
    endtask

    initial begin
        rst_n = 1'b0; en = 3'b000; req_n = 8'hFF; ack = 1'b0;
        tick(2);
        chk("rst_code", code, 0);
        chk("rst_valid", valid, 0);
        chk("rst_pending", pending, 0);
        chk("rst_ovr", ovr, 0);
        chk("rst_gs_n", gs_n, 1);
        rst_n = 1'b1;
        tick(2);

        // Single request: exact latency check.
        en = 3'b001; req_n = 8'hF7; sb_q.push_back(3'd3);
        tick(2 + X);
        chk("lat_pend_early", pending, 8'h00);
        tick(1);
        chk("lat_pend", pending, 8'h08);
        chk("lat_valid_early", valid, 0);
        chk("lat_gs_n_pend", gs_n, 0);
        tick(1);
        chk("lat_valid_k3", valid, 1);
        wait_present("single");
        ack_one("single");
        chk("single_pend_clr", pending, 8'h00);
        chk("single_gs_n", gs_n, 1);
        tick(4);
        chk("held_no_recapture", pending, 8'h00);
        req_n = 8'hFF; tick(4 + X);

        // Two simultaneous requests: the higher index goes first, then one idle cycle.
        req_n = 8'hBD; sb_q.push_back(3'd6); sb_q.push_back(3'd1);
        wait_present("dual_hi");
        ack_one("dual_hi");
        chk("dual_pend_left", pending, 8'h02);
        tick(1);
        chk("dual_after_idle", valid, 1);
        wait_present("dual_lo");
        ack_one("dual_lo");
        req_n = 8'hFF; tick(4 + X);

        // A higher-priority arrival does not preempt the current presentation.
        req_n = 8'hFB; sb_q.push_back(3'd2);
        wait_present("nopre_2");
        req_n = 8'h7B;
        tick(5 + X);
        chk("nopre_hold_code", code, 2);
        chk("nopre_hold_valid", valid, 1);
        chk("nopre_pend", pending, 8'h84);
        sb_q.push_back(3'd7);
        ack_one("nopre_2");
        wait_present("nopre_7");
        ack_one("nopre_7");
        req_n = 8'hFF; tick(4 + X);

        // ack is ignored while idle.
        ack = 1'b1; tick(1); ack = 1'b0;
        chk("idle_ack_valid", valid, 0);
        chk("idle_ack_pend", pending, 8'h00);

        // Captures are disabled when en != 001.
        en = 3'b000; req_n = 8'hFE; tick(PW); req_n = 8'hFF; tick(5 + X);
        chk("en_off_pend", pending, 8'h00);
        chk("en_off_valid", valid, 0);

        // Overrun: bit 0 is captured twice before any ack.
        en = 3'b001; sb_q.push_back(3'd0);
        req_n = 8'hFE; tick(PW); req_n = 8'hFF; tick(PW);
        chk("ovr_before", ovr, 0);
        req_n = 8'hFE; tick(PW); req_n = 8'hFF; tick(4 + X);
        chk("ovr_set", ovr, 1);
        wait_present("ovr");
        ack_one("ovr");
        tick(2);
        chk("ovr_sticky", ovr, 1);
        chk("ovr_pend", pending, 8'h00);

        // Asynchronous reset during a presentation, with a line held low through release.
        req_n = 8'hDF; sb_q.push_back(3'd5);
        wait_present("pre_rst");
        req_n = 8'hEF;
        rst_n = 1'b0;
        #1;
        chk("arst_valid", valid, 0);
        chk("arst_code", code, 0);
        chk("arst_pend", pending, 8'h00);
        chk("arst_ovr", ovr, 0);
        tick(2);
        rst_n = 1'b1; sb_q.push_back(3'd4);
        wait_present("post_rst");
        ack_one("post_rst");
        req_n = 8'hFF; tick(4 + X);

`ifdef ENC83_DEBOUNCE_EN
        // A 3-cycle glitch is filtered out. A 4-cycle stable low is captured.
        req_n = 8'hDF; tick(3); req_n = 8'hFF; tick(12);
        chk("deb_glitch_pend", pending, 8'h00);
        chk("deb_glitch_valid", valid, 0);
        req_n = 8'hDF; tick(4); req_n = 8'hFF; sb_q.push_back(3'd5);
        tick(4);
        chk("deb_stable_pend", pending, 8'h20);
        wait_present("deb");
        ack_one("deb");
        tick(12);
        chk("deb_release_pend", pending, 8'h00);
`endif

        chk("sb_drained", sb_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/priority_encoder_83.md
PRIORITY_ENCODER_83 -- requirements
Module: priority_encoder_83

Interface
REQ-001 SHALL have parameter DEB_CYCLES, default 4, debounce stability length in clk cycles (range 2..15; used only per REQ-025).
REQ-002 SHALL have port clk  input  1  sole clock, all state on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port en  input  3  capture enable, active only when en == 3'b001.
REQ-005 SHALL have port req_n  input  8  asynchronous request lines, active-low; bit 7 highest priority.
REQ-006 SHALL have port ack  input  1  consumer acknowledge of the presented code.
REQ-007 SHALL have port code  output  3  encoded index of the presented request.
REQ-008 SHALL have port valid  output  1  code is valid and held.
REQ-009 SHALL have port gs_n  output  1  group select, low while any request is pending or presented.
REQ-010 SHALL have port pending  output  8  pending-request register, active-high.
REQ-011 SHALL have port ovr  output  1  sticky overrun flag.

Function
REQ-012 SHALL pass each req_n bit through a two-flop synchronizer, then a previous-value register for edge detection.
REQ-013 SHALL set pending[i] on a detected 1->0 transition of synchronized bit i only while en == 3'b001; held-low levels SHALL NOT re-set a serviced bit until released and reasserted.
REQ-014 SHALL, with en != 3'b001, suppress new captures only; pending contents and an in-progress presentation SHALL be unaffected.
REQ-015 SHALL implement FSM states IDLE and PRESENT.
REQ-016 SHALL, in IDLE with pending != 0, register code = highest set pending index, set valid = 1, and enter PRESENT on the same edge.
REQ-017 SHALL, in PRESENT, hold code and valid stable until ack is sampled high; higher-priority arrivals SHALL NOT preempt.
REQ-018 SHALL, on ack sampled high in PRESENT, clear pending[code], drive valid = 0 and code = 3'b000, and return to IDLE (minimum one idle cycle between presentations).
REQ-019 SHALL ignore ack while in IDLE.
REQ-020 SHALL keep pending[i] = 1 when a new capture on bit i coincides with its clear by ack (set wins); sets and clears on different bits SHALL be independent.
REQ-021 SHALL set ovr when a capture occurs on a bit already pending (not being cleared that cycle); ovr SHALL clear only on reset.
REQ-022 SHALL drive gs_n = 0 whenever pending != 0 or valid = 1, else 1, derived from registers only.
REQ-023 SHALL give latency: req_n first sampled low at edge k -> pending set at edge k+2 -> valid high after edge k+3 (macro undefined, FSM in IDLE).

Reset
REQ-024 SHALL, on rst_n low, asynchronously force synchronizer/edge/filter flops to 1, pending = 8'h00, code = 3'b000, valid = 0, ovr = 0, state IDLE; a presentation in progress is abandoned; lines held low at release SHALL be captured as new edges.

Configuration
REQ-025 SHALL, with macro ENC83_DEBOUNCE_EN defined, insert a per-bit filter after the synchronizer: the filtered value changes only after the synchronized input differs from it for DEB_CYCLES consecutive cycles; edge detection uses the filtered value; latency of REQ-023 grows by DEB_CYCLES.
REQ-026 SHALL, with ENC83_DEBOUNCE_EN undefined, use the synchronized value directly, ignore DEB_CYCLES, and contain no filter logic.

Verification
REQ-027 SHALL verify: en=001, req_n=8'hF7 at edge k -> pending=8'h08 after k+2, valid=1 code=3 after k+3; ack one cycle -> pending=0, valid=0, gs_n=1.
REQ-028 SHALL verify: req_n bits 1 and 6 fall together -> code=6 first; after ack, code=1 presented after one idle cycle.
REQ-029 SHALL verify: code=2 presented, bit 7 falls -> code stays 2 until ack, then code=7.
REQ-030 SHALL verify: en=3'b000, req_n=8'hFE pulse -> pending stays 0; bit 0 pulsed twice before ack with en=001 -> ovr=1 until reset.
REQ-031 SHALL verify: rst_n low mid-PRESENT -> valid=0, code=0, pending=0 immediately (asynchronously); req_n=8'hEF held through release -> code=4 presented.
REQ-032 SHALL verify (ENC83_DEBOUNCE_EN, DEB_CYCLES=4): 3-cycle glitch on req_n[5] -> no capture; 4-cycle-stable low -> pending[5]=1.
